// File: rtl/regfile_write_buffer_if.sv
// Purpose: bundles the write-request, register-file drain, forwarding-lookup and status signals of the write buffer.
// Latency: none; this is wiring only.
// Backpressure: in_ready and rf_wready are carried here unchanged; the interface adds no flow control of its own.
interface regfile_write_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Write request from execute/write-back.
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;

  // Drain port into the register file.
  logic                  rf_we;
  logic                  rf_wready;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  // Decode-side forwarding lookups.
  logic [ADDR_WIDTH-1:0] lookup_addr1;
  logic [ADDR_WIDTH-1:0] lookup_addr2;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_WIDTH-1:0] fwd_data1;
  logic [DATA_WIDTH-1:0] fwd_data2;

  // Occupancy status.
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;

  // Master side: the pipeline and register file around the buffer.
  modport master (
    output in_valid, in_addr, in_data, rf_wready, lookup_addr1, lookup_addr2,
    input  in_ready, rf_we, rf_waddr, rf_wdata, hit1, hit2, fwd_data1, fwd_data2,
    input  count, full, empty
  );

  // Slave side: the write buffer itself.
  modport slave (
    input  in_valid, in_addr, in_data, rf_wready, lookup_addr1, lookup_addr2,
    output in_ready, rf_we, rf_waddr, rf_wdata, hit1, hit2, fwd_data1, fwd_data2,
    output count, full, empty
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// Purpose: in-order write-back queue in front of the register file, with youngest-match forwarding for two read lookups.
// Latency: an entry pushed into an empty buffer is presented on rf_we/rf_waddr/rf_wdata one cycle later; there is no bypass.
// Backpressure: in_ready = !full, and a pop in the same cycle does not relax it. The head drains when rf_wready is high.
module regfile_write_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int DROP_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage, indexed by the ring pointers.
  logic [ADDR_WIDTH-1:0] entryAddr [DEPTH];
  logic [DATA_WIDTH-1:0] entryData [DEPTH];
  logic [DEPTH-1:0]      entryValid;

  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_W-1:0]      occupancy;

  // Goes high at the first edge after reset is released.
  // It keeps in_ready low while the block is in reset.
  logic                  running;

  logic                  isFull;
  logic                  isEmpty;
  logic                  acceptIn;
  logic                  pushHs;
  logic                  dropWrite;
  logic                  storeEn;
  logic                  popEn;

  logic [PTR_W-1:0]      scanIdx;
  logic                  hitA;
  logic                  hitB;
  logic [DATA_WIDTH-1:0] fwdA;
  logic [DATA_WIDTH-1:0] fwdB;

  // full/empty depend only on the count. A pointer match alone cannot tell full from empty.
  assign isFull   = (occupancy == CNT_W'(DEPTH));
  assign isEmpty  = (occupancy == '0);
  assign acceptIn = running && !isFull;

  // A write to x0 completes its handshake, but the entry is thrown away.
  assign pushHs    = bus.in_valid && acceptIn;
  assign dropWrite = (DROP_ZERO != 0) && (bus.in_addr == '0);
  assign storeEn   = pushHs && !dropWrite;
  assign popEn     = !isEmpty && bus.rf_wready;

  assign bus.in_ready = acceptIn;
  assign bus.count    = occupancy;
  assign bus.full     = isFull;
  assign bus.empty    = isEmpty;

  // The drain port shows the head entry, or zeros when the buffer is empty.
  assign bus.rf_we    = !isEmpty;
  assign bus.rf_waddr = isEmpty ? '0 : entryAddr[rdPtr];
  assign bus.rf_wdata = isEmpty ? '0 : entryData[rdPtr];

  // Set the run flag once the first edge with reset released has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  // Advance the ring pointers and the occupancy count on push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (storeEn) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      unique case ({storeEn, popEn})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Write the entry payload and keep the per-entry valid bits current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entryValid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr[i] <= '0;
        entryData[i] <= '0;
      end
    end else begin
      // Clear before set, although a pop and a push never hit the same slot.
      // A push needs a free slot, and a pop needs an occupied one.
      if (popEn) begin
        entryValid[rdPtr] <= 1'b0;
      end
      if (storeEn) begin
        entryValid[wrPtr] <= 1'b1;
        entryAddr[wrPtr]  <= bus.in_addr;
        entryData[wrPtr]  <= bus.in_data;
      end
    end
  end

  // Forward the youngest stored match for each lookup.
  // The scan runs from oldest to youngest, so a later match overwrites an earlier one.
  // The head entry still hits in the cycle it pops. The request arriving this cycle is not visible yet.
  always_comb begin
    hitA    = 1'b0;
    hitB    = 1'b0;
    fwdA    = '0;
    fwdB    = '0;
    scanIdx = rdPtr;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = rdPtr + PTR_W'(k);
      if (entryValid[scanIdx] && (entryAddr[scanIdx] == bus.lookup_addr1)) begin
        hitA = 1'b1;
        fwdA = entryData[scanIdx];
      end
      if (entryValid[scanIdx] && (entryAddr[scanIdx] == bus.lookup_addr2)) begin
        hitB = 1'b1;
        fwdB = entryData[scanIdx];
      end
    end
    // x0 is never forwarded when zero-register writes are dropped.
    if ((DROP_ZERO != 0) && (bus.lookup_addr1 == '0)) begin
      hitA = 1'b0;
      fwdA = '0;
    end
    if ((DROP_ZERO != 0) && (bus.lookup_addr2 == '0)) begin
      hitB = 1'b0;
      fwdB = '0;
    end
  end

  assign bus.hit1      = hitA;
  assign bus.hit2      = hitB;
  assign bus.fwd_data1 = fwdA;
  assign bus.fwd_data2 = fwdB;

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Write-back queue in front of the 32x32 register file.
- Accepts register write requests from the execute/write-back stage with a valid/ready handshake and buffers up to DEPTH of them in order.
- Drains one entry per cycle into the register file write port whenever the file can accept a write.
- Forwards the youngest pending value for two read lookups, so decode reads see data not yet committed to the file.

Parameters:
DATA_WIDTH, 32, width of write data.
ADDR_WIDTH, 5, register address width.
DEPTH, 4, number of buffer entries; power of two, at least 2.
DROP_ZERO, 1, when 1, writes to address 0 are accepted but discarded, and address 0 never hits.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  write request present.
in_ready  output  1  buffer can accept a request this cycle.
in_addr  input  ADDR_WIDTH  destination register.
in_data  input  DATA_WIDTH  write value.
rf_we  output  1  head entry presented to the register file.
rf_wready  input  1  register file accepts the write at this edge.
rf_waddr  output  ADDR_WIDTH  head entry address.
rf_wdata  output  DATA_WIDTH  head entry data.
lookup_addr1  input  ADDR_WIDTH  read-port-1 address to check.
lookup_addr2  input  ADDR_WIDTH  read-port-2 address to check.
hit1  output  1  lookup_addr1 matches a pending entry.
hit2  output  1  lookup_addr2 matches a pending entry.
fwd_data1  output  DATA_WIDTH  youngest matching data for port 1; 0 when no hit.
fwd_data2  output  DATA_WIDTH  youngest matching data for port 2; 0 when no hit.
count  output  $clog2(DEPTH)+1  occupied entries.
full  output  1  count == DEPTH.
empty  output  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous): write/read pointers = 0, count = 0, all entry valid bits cleared.
  - Outputs during reset: rf_we = 0, rf_waddr = 0, rf_wdata = 0, hit1/hit2 = 0, fwd_data = 0, empty = 1, full = 0, in_ready = 0.
  - in_ready rises only in the first cycle after rst_n is sampled high.
- Push: occurs at the edge where in_valid & in_ready.
  - Entry is stored at the write pointer, which then increments modulo DEPTH.
  - If DROP_ZERO=1 and in_addr == 0, the handshake completes but nothing is stored and count is unchanged.
- in_ready = !full. It is not relaxed when a pop happens in the same cycle; a full buffer refuses input even while draining.
- Drain is combinational from state: rf_we = !empty, with rf_waddr/rf_wdata = head entry.
  - Pop at the edge where rf_we & rf_wready; the read pointer increments modulo DEPTH.
  - When empty, rf_waddr/rf_wdata are 0.
- Latency: a request pushed at edge N appears on rf_we/rf_waddr/rf_wdata after edge N if the buffer was empty. There is no input-to-output bypass.
- Simultaneous push and pop: both take effect and count is unchanged. When count == 1, the new entry becomes head after the edge.
- Forwarding is combinational over stored entries only.
  - Scan from youngest to oldest; the first address match wins.
  - The incoming request in the same cycle is not visible.
  - An entry being popped this cycle still hits this cycle.
- Duplicate addresses in the buffer are legal. The youngest supplies forwarded data, and all duplicates drain in order.
- Pointer wrap: pointers are ADDR of $clog2(DEPTH) bits plus count. full/empty derive from count only.
- Mid-operation reset discards all pending entries; no partial write is issued.

Test Plan:
1. Reset, then push (1, 10) and (2, 20) back-to-back with rf_wready=0 -> count=2, rf_we=1, rf_waddr=1, rf_wdata=10, in_ready=1.
2. Push (3, 30), (3, 33) with rf_wready=0; lookup_addr1=3, lookup_addr2=4 -> hit1=1, fwd_data1=33, hit2=0, fwd_data2=0. Then set rf_wready=1 -> drain order (3, 30) then (3, 33); hit1 stays 1 through the pop cycle of the last entry, then drops.
3. Fill DEPTH=4 entries with rf_wready=0 -> full=1, in_ready=0, and a fifth in_valid is ignored. Assert rf_wready for one cycle -> count=3, in_ready=1 the next cycle.
4. Hold in_valid and rf_wready high for 12 cycles with addresses 5..16 -> count stays 1 after the first push, pointers wrap three times, and the rf output sequence equals the input sequence delayed one cycle.
5. Push (0, 99) with DROP_ZERO=1 -> in_ready handshake completes, count stays 0, and lookup_addr1=0 gives hit1=0.
6. With 3 entries pending, pulse rst_n low mid-cycle -> rf_we=0 and count=0 immediately; after release, a push of (7, 70) drains as the first write.
